// File: rtl/lfsr_period_monitor.sv
// Measures the cycle length of a 4-bit LFSR stream: captures the state seen one
// edge after load, counts edges until it recurs, and flags lockup or early repeats.
module lfsr_period_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] state,
    output logic [3:0] period,
    output logic       done,
    output logic       maximal,
    output logic       err_lockup,
    output logic       err_repeat,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        COUNT,
        DONE,
        ERR
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [3:0]  count_q, count_d, count_inc;
    logic [3:0]  ref_q, ref_d;
    logic [15:0] visited_q, visited_d;
    logic [3:0]  period_d;
    logic        done_d, maximal_d, lockup_d, repeat_d;

    assign count_inc = count_q + 4'd1;
    assign busy      = (fsm_q == ARM) || (fsm_q == COUNT);

    // NOTE: every register, including the visited bitmap, has an async reset so
    // a mid-measurement reset leaves no stale history for the next run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= IDLE;
            count_q    <= '0;
            ref_q      <= '0;
            visited_q  <= '0;
            period     <= '0;
            maximal    <= 1'b0;
            done       <= 1'b0;
            err_lockup <= 1'b0;
            err_repeat <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            fsm_q      <= fsm_d;
            count_q    <= count_d;
            ref_q      <= ref_d;
            visited_q  <= visited_d;
            period     <= period_d;
            maximal    <= maximal_d;
            done       <= done_d;
            err_lockup <= lockup_d;
            err_repeat <= repeat_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a latch.
        fsm_d     = fsm_q;
        count_d   = count_q;
        ref_d     = ref_q;
        visited_d = visited_q;
        period_d  = period;
        maximal_d = maximal;
        done_d    = 1'b0;
        lockup_d  = err_lockup;
        repeat_d  = err_repeat;

        if (load) begin
            // Seed load restarts from any state; the previous result stays visible.
            fsm_d     = ARM;
            count_d   = '0;
            visited_d = '0;
            lockup_d  = 1'b0;
            repeat_d  = 1'b0;
        end else begin
            case (fsm_q)
                ARM: begin
                    ref_d   = state;
                    count_d = '0;
                    if (state == 4'd0) begin
                        lockup_d = 1'b1;
                        fsm_d    = ERR;
                    end else begin
                        visited_d[state] = 1'b1;
                        fsm_d            = COUNT;
                    end
                end
                COUNT: begin
                    count_d = count_inc;
                    if (state == 4'd0) begin
                        lockup_d = 1'b1;
                        fsm_d    = ERR;
                    end else if (state == ref_q) begin
                        period_d  = count_inc;
                        maximal_d = (count_inc == 4'd15);
                        done_d    = 1'b1;
                        fsm_d     = DONE;
                    end else if (visited_q[state]) begin
                        repeat_d = 1'b1;
                        fsm_d    = ERR;
                    end else begin
                        visited_d[state] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor: drives a modelled x^4+x^3+1 LFSR and
// hand-built streams, checking every output against hand-derived values.
module tb_lfsr_period_monitor;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] state;
    logic [3:0] period;
    logic       done;
    logic       maximal;
    logic       err_lockup;
    logic       err_repeat;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    lfsr_period_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .state      (state),
        .period     (period),
        .done       (done),
        .maximal    (maximal),
        .err_lockup (err_lockup),
        .err_repeat (err_repeat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] per, input logic dn,
                              input logic mx, input logic lk, input logic rp, input logic bz);
        check({tag, ".period"},     {4'd0, period}, {4'd0, per});
        check({tag, ".done"},       {7'd0, done},       {7'd0, dn});
        check({tag, ".maximal"},    {7'd0, maximal},    {7'd0, mx});
        check({tag, ".err_lockup"}, {7'd0, err_lockup}, {7'd0, lk});
        check({tag, ".err_repeat"}, {7'd0, err_repeat}, {7'd0, rp});
        check({tag, ".busy"},       {7'd0, busy},       {7'd0, bz});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic tick(input logic l, input logic [3:0] s);
        load  = l;
        state = s;
        @(posedge clk);
        #1;
    endtask

    // One load cycle, then the connected LFSR's output: seed first, 15 steps later seed again.
    task automatic run_lfsr(input logic [3:0] seed, input logic [3:0] held);
        logic [3:0] s;
        tick(1'b1, 4'h0);
        check_outs("run_arm", held, 1'b0, maximal, 1'b0, 1'b0, 1'b1);
        tick(1'b0, seed);
        check("run_capture.busy", {7'd0, busy}, 8'd1);
        s = seed;
        for (int i = 1; i <= 15; i++) begin
            s = lfsr_next(s);
            tick(1'b0, s);
            if (i < 15) check("run_step.done", {7'd0, done}, 8'd0);
            if (i == 8) check("run_hold.period", {4'd0, period}, {4'd0, held});
        end
        check_outs("run_complete", 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, lfsr_next(s));
        check_outs("run_after", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] s;
        logic [3:0] short_seq [5];
        short_seq[0] = 4'd6;
        short_seq[1] = 4'd12;
        short_seq[2] = 4'd11;
        short_seq[3] = 4'd5;
        short_seq[4] = 4'd10;

        reset = 1'b0;
        load  = 1'b0;
        state = 4'h0;
        #2;
        check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #10 reset = 1'b1;

        // Idle without load: nothing moves.
        tick(1'b0, 4'h7);
        tick(1'b0, 4'h0);
        check_outs("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Maximal run from seed 1111, period held at 0 while counting.
        run_lfsr(4'hF, 4'd0);

        // Short cycle 3,6,12,11,5,10.
        tick(1'b1, 4'h0);
        tick(1'b0, 4'd3);
        foreach (short_seq[i]) begin
            tick(1'b0, short_seq[i]);
            check("short_step.done", {7'd0, done}, 8'd0);
        end
        check("short_hold.period", {4'd0, period}, 8'd15);
        tick(1'b0, 4'd3);
        check_outs("short_complete", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd6);
        check_outs("short_after", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back seeds; period holds its previous value until each new done.
        run_lfsr(4'hA, 4'd6);
        run_lfsr(4'h9, 4'd15);

        // Lockup: seed 0000.
        tick(1'b1, 4'h5);
        tick(1'b0, 4'h0);
        check_outs("lockup", 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 4'h0);
        check_outs("lockup_hold", 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Repeat: ref 5, then 3,7,3.
        tick(1'b1, 4'h0);
        check("repeat_load.err_lockup", {7'd0, err_lockup}, 8'd0);
        tick(1'b0, 4'd5);
        tick(1'b0, 4'd3);
        tick(1'b0, 4'd7);
        check_outs("repeat_pre", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 4'd3);
        check_outs("repeat", 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Abort: load mid-count, then a full fresh measurement.
        tick(1'b1, 4'h0);
        tick(1'b0, 4'hF);
        s = 4'hF;
        for (int i = 0; i < 4; i++) begin
            s = lfsr_next(s);
            tick(1'b0, s);
        end
        check_outs("abort_pre", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_lfsr(4'hF, 4'd15);

        // Reset between edges mid-count.
        tick(1'b1, 4'h0);
        tick(1'b0, 4'hF);
        s = 4'hF;
        for (int i = 0; i < 3; i++) begin
            s = lfsr_next(s);
            tick(1'b0, s);
        end
        #3 reset = 1'b0;
        #1;
        check_outs("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick(1'b0, 4'hF);
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h3);
        check_outs("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
